// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer and its register file.
// Holds the FSM state encoding, the ALU function codes, the branch condition
// codes, the illegal-op threshold, the flag bit positions and the helper that
// resolves a branch condition against a flag vector.
package alu_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_EXEC,
      ST_WB
   } seq_state_t;

   // ALU function codes understood by the external ALU
   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_CMP  = 5'b00011;
   localparam logic [4:0] OP_OR   = 5'b00100;
   localparam logic [4:0] OP_XOR  = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SRA  = 5'b01000;
   localparam logic [4:0] OP_NOP  = 5'b01001;
   localparam logic [4:0] OP_MUL  = 5'b01010;
   localparam logic [4:0] OP_NOT  = 5'b01011;
   localparam logic [4:0] OP_NAND = 5'b01100;
   localparam logic [4:0] OP_NOR  = 5'b01101;
   localparam logic [4:0] OP_PASS = 5'b01110;
   localparam logic [4:0] OP_MIN  = 5'b01111;

   // Any function code at or above this value is rejected
   localparam logic [4:0] OP_ILLEGAL_MIN = 5'b10000;

   // Branch condition codes
   localparam logic [2:0] COND_ALWAYS = 3'b000;
   localparam logic [2:0] COND_EQU    = 3'b001;
   localparam logic [2:0] COND_NEQU   = 3'b010;
   localparam logic [2:0] COND_GT     = 3'b011;
   localparam logic [2:0] COND_LT     = 3'b100;
   localparam logic [2:0] COND_GE     = 3'b101;
   localparam logic [2:0] COND_LE     = 3'b110;
   localparam logic [2:0] COND_NEVER  = 3'b111;

   // Bit positions inside the packed flag vector {le,ge,lt,gt,nequ,equ}
   localparam int FLAG_EQU  = 0;
   localparam int FLAG_NEQU = 1;
   localparam int FLAG_GT   = 2;
   localparam int FLAG_LT   = 3;
   localparam int FLAG_GE   = 4;
   localparam int FLAG_LE   = 5;

   // Resolves a branch condition against a flag vector
   function automatic logic cond_met(input logic [2:0] cond, input logic [5:0] flags);
      logic met;
      met = 1'b0;
      case (cond)
         COND_ALWAYS: met = 1'b1;
         COND_EQU:    met = flags[FLAG_EQU];
         COND_NEQU:   met = flags[FLAG_NEQU];
         COND_GT:     met = flags[FLAG_GT];
         COND_LT:     met = flags[FLAG_LT];
         COND_GE:     met = flags[FLAG_GE];
         COND_LE:     met = flags[FLAG_LE];
         COND_NEVER:  met = 1'b0;
         default:     met = 1'b0;
      endcase
      return met;
   endfunction

endpackage

// File: rtl/seq_regfile.sv
// Register file for the ALU sequencer.
// Two asynchronous read ports, one synchronous write port, all entries reset
// to zero. Entry 0 is hard-wired to read zero and ignores writes.
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   rd_idx_a / rd_data_a  read port A
//   rd_idx_b / rd_data_b  read port B
//   wr_en, wr_idx, wr_data write port, committed on the rising edge
module seq_regfile #(
   parameter int DATA_W = 32,
   parameter int REG_COUNT = 8,
   localparam int IDX_W = $clog2(REG_COUNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  rd_idx_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [IDX_W-1:0]  rd_idx_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] regs [REG_COUNT];

   // Storage: cleared by reset, written on the rising edge; writes to entry 0
   // are dropped so it always reads back as zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en && (wr_idx != '0)) begin
         regs[wr_idx] <= wr_data;
      end
   end

   assign rd_data_a = (rd_idx_a == '0) ? '0 : regs[rd_idx_a];
   assign rd_data_b = (rd_idx_b == '0) ? '0 : regs[rd_idx_b];

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer that steps one command at a time through an external ALU.
// Each accepted command walks IDLE -> READ -> EXEC -> WB, one cycle each:
// operands are fetched from the register file in READ, the ALU is driven in
// EXEC and its result and flags are sampled at the end of EXEC, and the
// response is presented (and the result written back) during WB.
// Ports:
//   clk, rst                          clock and asynchronous active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_op, cmd_rd, cmd_rs1, cmd_rs2  function code and register indices
//   cmd_imm, cmd_use_imm, cmd_cond    immediate, immediate select, branch condition
//   alu_func, alu_in1, alu_in2, alu_imm_in, alu_imm   ALU drive (zero outside EXEC)
//   alu_outp, alu_equ..alu_le         ALU result and flags
//   rsp_valid, rsp_data, rsp_flags, rsp_taken, rsp_err   one-cycle response
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_COUNT = 8,
   localparam int IDX_W = $clog2(REG_COUNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [4:0]        cmd_op,
   input  logic [IDX_W-1:0]  cmd_rd,
   input  logic [IDX_W-1:0]  cmd_rs1,
   input  logic [IDX_W-1:0]  cmd_rs2,
   input  logic [DATA_W-1:0] cmd_imm,
   input  logic              cmd_use_imm,
   input  logic [2:0]        cmd_cond,
   output logic [4:0]        alu_func,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [DATA_W-1:0] alu_imm_in,
   output logic              alu_imm,
   input  logic [DATA_W-1:0] alu_outp,
   input  logic              alu_equ,
   input  logic              alu_nequ,
   input  logic              alu_gt,
   input  logic              alu_lt,
   input  logic              alu_ge,
   input  logic              alu_le,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [5:0]        rsp_flags,
   output logic              rsp_taken,
   output logic              rsp_err
);

   seq_state_t        state, state_next;
   logic [4:0]        op_q;
   logic [IDX_W-1:0]  rd_q, rs1_q, rs2_q;
   logic [DATA_W-1:0] imm_q;
   logic              use_imm_q;
   logic [2:0]        cond_q;
   logic [DATA_W-1:0] op_a, op_b;
   logic [DATA_W-1:0] rf_data_a, rf_data_b;
   logic [5:0]        flag_q;
   logic [5:0]        alu_flags;
   logic              op_illegal;
   logic              wb_en;

   assign alu_flags  = {alu_le, alu_ge, alu_lt, alu_gt, alu_nequ, alu_equ};
   assign op_illegal = (op_q >= OP_ILLEGAL_MIN);

   // The write-back data is the ALU result sampled at the end of EXEC, which
   // is exactly what rsp_data holds during WB
   seq_regfile #(
      .DATA_W(DATA_W),
      .REG_COUNT(REG_COUNT)
   ) u_regfile (
      .clk(clk),
      .rst(rst),
      .rd_idx_a(rs1_q),
      .rd_data_a(rf_data_a),
      .rd_idx_b(rs2_q),
      .rd_data_b(rf_data_b),
      .wr_en(wb_en),
      .wr_idx(rd_q),
      .wr_data(rsp_data)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and per-state outputs; the ALU is only driven during EXEC and
   // compares, no-ops and illegal ops never write back
   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      alu_func   = '0;
      alu_in1    = '0;
      alu_in2    = '0;
      alu_imm_in = '0;
      alu_imm    = 1'b0;
      wb_en      = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_next = ST_READ;
            end
         end
         ST_READ: begin
            state_next = ST_EXEC;
         end
         ST_EXEC: begin
            state_next = ST_WB;
            alu_func   = op_q;
            alu_in1    = op_a;
            alu_in2    = op_b;
            alu_imm_in = imm_q;
            alu_imm    = use_imm_q;
         end
         ST_WB: begin
            state_next = ST_IDLE;
            wb_en = (rd_q != '0) && (op_q != OP_CMP) && (op_q != OP_NOP) && !op_illegal;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Command capture on the handshake edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q      <= '0;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         imm_q     <= '0;
         use_imm_q <= 1'b0;
         cond_q    <= '0;
      end else if (cmd_ready && cmd_valid) begin
         op_q      <= cmd_op;
         rd_q      <= cmd_rd;
         rs1_q     <= cmd_rs1;
         rs2_q     <= cmd_rs2;
         imm_q     <= cmd_imm;
         use_imm_q <= cmd_use_imm;
         cond_q    <= cmd_cond;
      end
   end

   // Operand fetch at the end of READ
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a <= '0;
         op_b <= '0;
      end else if (state == ST_READ) begin
         op_a <= rf_data_a;
         op_b <= rf_data_b;
      end
   end

   // Result and flag sampling at the end of EXEC. Illegal ops leave the flag
   // register alone and report its existing contents, never a taken branch.
   // Outside that edge the response fields hold their last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_q    <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_flags <= '0;
         rsp_taken <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= (state == ST_EXEC);
         if (state == ST_EXEC) begin
            rsp_data <= alu_outp;
            rsp_err  <= op_illegal;
            if (op_illegal) begin
               rsp_flags <= flag_q;
               rsp_taken <= 1'b0;
            end else begin
               flag_q    <= alu_flags;
               rsp_flags <= alu_flags;
               rsp_taken <= cond_met(cond_q, alu_flags);
            end
         end
      end
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width.
REQ-002 Parameter REG_COUNT, default 8, register file entries; the module SHALL drive index width $clog2(REG_COUNT).
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1 / cmd_ready  out  1  command handshake; transfer when both are high at a clock edge.
REQ-006 cmd_op  in  5  ALU function code / cmd_rd, cmd_rs1, cmd_rs2  in  3  register indices.
REQ-007 cmd_imm  in  DATA_W / cmd_use_imm  in  1  immediate replaces rs1 operand / cmd_cond  in  3  branch condition.
REQ-008 alu_func  out  5 / alu_in1, alu_in2, alu_imm_in  out  DATA_W / alu_imm  out  1  drive the ALU.
REQ-009 alu_outp  in  DATA_W / alu_equ, alu_nequ, alu_gt, alu_lt, alu_ge, alu_le  in  1  ALU result and flags.
REQ-010 rsp_valid  out  1 / rsp_data  out  DATA_W / rsp_flags  out  6 {le,ge,lt,gt,nequ,equ} / rsp_taken  out  1 / rsp_err  out  1.

Function
REQ-011 FSM states IDLE, READ, EXEC, WB; transitions IDLE->READ on handshake, READ->EXEC, EXEC->WB, WB->IDLE, each unconditional after one cycle.
REQ-012 cmd_ready SHALL be 1 only in IDLE; one command is in flight at a time; throughput one command per 4 cycles.
REQ-013 On handshake, op, rd, rs1, rs2, imm, use_imm, cond SHALL be captured into internal registers.
REQ-014 READ: register file read of rs1 and rs2 into operand registers; r0 SHALL always read 0.
REQ-015 EXEC: alu_func=op, alu_in1=opA, alu_in2=opB, alu_imm_in=imm, alu_imm=use_imm; alu_outp and all six flags SHALL be sampled at the end of EXEC.
REQ-016 Outside EXEC, all alu_* outputs SHALL be 0.
REQ-017 WB: result written to rd unless rd==0, op==5'b00011 (compare), op==5'b01001 (no-op), or op>=5'b10000.
REQ-018 op>=5'b10000 is illegal: no writeback, flag register unchanged, rsp_err=1; otherwise rsp_err=0.
REQ-019 Legal ops SHALL update the flag register with the sampled flags.
REQ-020 rsp_valid SHALL pulse exactly one cycle, in WB, three cycles after the handshake edge; rsp_data/rsp_flags/rsp_taken/rsp_err valid only then, held at last value otherwise.
REQ-021 rsp_taken from flags sampled in this EXEC: cond 000 always, 001 equ, 010 nequ, 011 gt, 100 lt, 101 ge, 110 le, 111 never; for illegal ops rsp_taken=0.
REQ-022 cmd_valid while not ready SHALL be ignored; the command SHALL NOT be captured until a later handshake.
REQ-023 Arithmetic width is that of the ALU; no carry or overflow is tracked; results are stored modulo 2^DATA_W.

Reset
REQ-024 rst SHALL immediately force IDLE, clear all registers and the flag register to 0, and set rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_taken=0, rsp_err=0, and all alu_* outputs to 0.
REQ-025 rst during READ/EXEC/WB SHALL abort the command with no writeback and no rsp_valid; cmd_ready SHALL be 1 in the first cycle after deassertion.

Structure
REQ-026 The shared package SHALL hold the state enum, the op-code constants (5'b00000..5'b01111), the condition-code constants, and the illegal-op threshold.
REQ-027 The register file SHALL be a sub-module named seq_regfile with two asynchronous read ports and one write port, reset to zero.

Verification
REQ-028 After reset, r1=5 via op 00000, imm=5, use_imm=1, rd=1 -> rsp_valid 3 cycles after the handshake; rsp_data=5; r1=5.
REQ-029 With r1=5 and r2=5: op 00011, rs1=1, rs2=2, cond=001 -> rsp_flags.equ=1, rsp_taken=1, and no register changes.
REQ-030 Add 0xFFFFFFFF+1 into rd=0 -> rsp_data=0, equ=1, r0 still reads 0.
REQ-031 op 10101 -> rsp_err=1, rsp_taken=0, flag register unchanged.
REQ-032 Back-to-back cmd_valid held high -> cmd_ready high one cycle in four; reset asserted in EXEC -> no rsp_valid, no writeback, and cmd_ready=1 one cycle after release.
